// File: rtl/rom_arb_pkg.sv
// Shared constants and helpers for the round-robin ROM arbiter.
// Optional requester locking is enabled with the ROM_ARB_LOCK_EN macro.
package rom_arb_pkg;

    // Clock edges between a grant and its response on rsp_*.
    localparam int RSP_LATENCY = 1;

    // ID width: $clog2 would give 0 for a single requester, so the result is clamped to 1.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the valid vector by ptr, take the
// lowest set bit, then rotate the result back to an absolute requester index.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_valid,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_gnt,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

    logic [2*N-1:0]  w_dbl;
    logic [N-1:0]    w_rot;
    logic [ID_W-1:0] w_off;
    logic [ID_W:0]   w_sum;

    // Doubling the vector turns the wrap-around rotate into a plain part-select.
    assign w_dbl = {i_valid, i_valid};
    assign w_rot = w_dbl[{1'b0, i_ptr} +: N];

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_off = '0;
        o_any = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = ID_W'(j);
                o_any = 1'b1;
            end
        end
    end

    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= N_W) ? ID_W'(w_sum - N_W) : ID_W'(w_sum);
    assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency ROM between NUM_REQ clients.
// Define ROM_ARB_LOCK_EN to add req_lock, letting a winner keep the grant.
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
`ifdef ROM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [WIDTH-1:0]          rom_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [WIDTH-1:0]          rsp_data
);

    logic [ID_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]  r_last_addr;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;

    logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic               w_adv;
    logic [ID_W-1:0]    w_ptr_nxt;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

`ifdef ROM_ARB_LOCK_EN
    logic            r_lock;
    logic [ID_W-1:0] r_lock_id;
    logic            w_hold;

    // A held lock only survives while its owner keeps requesting.
    assign w_hold = r_lock && req_valid[r_lock_id];

    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        w_any = 1'b0;
        if (!rst) begin
            if (w_hold) begin
                w_gnt = NUM_REQ'(1) << r_lock_id;
                w_idx = r_lock_id;
                w_any = 1'b1;
            end else begin
                w_gnt = w_pick_gnt;
                w_idx = w_pick_idx;
                w_any = w_pick_any;
            end
        end
    end

    assign w_adv = w_any && !req_lock[w_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_any) begin
            r_lock    <= req_lock[w_idx];
            r_lock_id <= w_idx;
        end else begin
            r_lock    <= 1'b0;
        end
    end
`else
    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        w_any = 1'b0;
        if (!rst) begin
            w_gnt = w_pick_gnt;
            w_idx = w_pick_idx;
            w_any = w_pick_any;
        end
    end

    assign w_adv = w_any;
`endif

    assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_last_addr <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_any;
            if (w_any) begin
                r_rsp_id    <= w_idx;
                r_last_addr <= w_addr_arr[w_idx];
            end
            if (w_adv) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // Idle cycles replay the last address so the ROM input does not toggle.
    assign req_ready = w_gnt;
    assign rom_addr  = w_any ? w_addr_arr[w_idx] : r_last_addr;
    assign rsp_valid = r_rsp_valid && !rst;
    assign rsp_id    = rst ? '0 : r_rsp_id;
    assign rsp_data  = rom_data;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Self-checking bench for rom_rr_arbiter: directed cases plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_rom_rr_arbiter;
    import rom_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [AW-1:0] addr_q [N];
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  req_ready;
    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_data;
    logic          rsp_valid;
    logic [IW-1:0] rsp_id;
    logic [W-1:0]  rsp_data;
`ifdef ROM_ARB_LOCK_EN
    logic [N-1:0]  req_lock = '0;
`endif

    logic [W-1:0]  rom_mem [D];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = addr_q[g];
    end

    always #5 clk = ~clk;

    // ROM model: registered read, one cycle of latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    rom_rr_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .DEPTH   (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
`ifdef ROM_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int id;
        int addr;
    } pend_t;

    pend_t pq[$];
    int    m_ptr = 0;
    int    m_last_addr = 0;
    bit    m_lock = 1'b0;
    int    m_lock_id = 0;

    function automatic void refill_idle();
        pend_t e;
        e.v = 1'b0; e.id = 0; e.addr = 0;
        pq.delete();
        for (int k = 0; k < RSP_LATENCY; k++) pq.push_back(e);
    endfunction

    initial refill_idle();

    always @(negedge clk) begin
        int    widx;
        pend_t head;
        pend_t cur;
        if (mon_en) begin
            widx = -1;
            if (!rst) begin
                if (m_lock && req_valid[m_lock_id]) widx = m_lock_id;
                else begin
                    for (int k = 0; k < N; k++) begin
                        if (widx < 0 && req_valid[(m_ptr + k) % N]) widx = (m_ptr + k) % N;
                    end
                end
            end
            head = pq.pop_front();
            check("req_ready", req_ready, (widx >= 0) ? (32'd1 << widx) : 32'd0);
            check("rom_addr", rom_addr, (widx >= 0) ? addr_q[widx] : m_last_addr);
            check("rsp_valid", rsp_valid, head.v && !rst);
            if (head.v && !rst) begin
                check("rsp_id", rsp_id, head.id);
                check("rsp_data", rsp_data, rom_mem[head.addr]);
            end
            if (rst) begin
                m_ptr = 0; m_last_addr = 0; m_lock = 1'b0; m_lock_id = 0;
                refill_idle();
            end else begin
                cur.v = (widx >= 0); cur.id = widx; cur.addr = 0;
                if (widx >= 0) begin
                    cur.addr = addr_q[widx];
                    m_last_addr = addr_q[widx];
`ifdef ROM_ARB_LOCK_EN
                    m_lock = req_lock[widx];
                    m_lock_id = widx;
                    if (!req_lock[widx]) m_ptr = (widx + 1) % N;
`else
                    m_ptr = (widx + 1) % N;
`endif
                end else begin
                    m_lock = 1'b0;
                end
                pq.push_back(cur);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
`ifdef ROM_ARB_LOCK_EN
        req_lock = '0;
`endif
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int order [6];
        int mode;
        for (int i = 0; i < D; i++) rom_mem[i] = W'($urandom);
        rom_mem[5] = 8'hA5;
        for (int i = 0; i < N; i++) addr_q[i] = '0;

        next_cycle();
        mon_en = 1'b1;
        next_cycle();
        rst = 1'b0;

        // Idle after reset.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_ready", req_ready, 0);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_rom_addr", rom_addr, 0);
            next_cycle();
        end

        // Single request from 2 at address 5.
        req_valid = 4'b0100;
        addr_q[2] = 4'd5;
        @(negedge clk);
        check("single_ready", req_ready, 4'b0100);
        check("single_rom_addr", rom_addr, 5);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_id", rsp_id, 2);
        check("single_rsp_data", rsp_data, 8'hA5);
        next_cycle();

        // All four valid: strict rotation with no bubbles.
        do_reset();
        order = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < N; i++) addr_q[i] = AW'(i);
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rot_ready", req_ready, 32'd1 << order[c]);
            if (c > 0) begin
                check("rot_rsp_valid", rsp_valid, 1);
                check("rot_rsp_id", rsp_id, order[c-1]);
                check("rot_rsp_data", rsp_data, rom_mem[order[c-1]]);
            end
            next_cycle();
        end
        req_valid = '0;
        next_cycle();

        // Requesters 1 and 3 with ptr parked at 2.
        do_reset();
        req_valid = 4'b0010;
        addr_q[1] = 4'd7;
        @(negedge clk);
        check("p2_setup_ready", req_ready, 4'b0010);
        next_cycle();
        req_valid = 4'b1010;
        addr_q[3] = 4'd9;
        order = '{3, 1, 3, 0, 0, 0};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("p2_ready", req_ready, 32'd1 << order[c]);
            next_cycle();
        end
        req_valid = '0;
        next_cycle();

        // Reset the cycle after a grant: response dropped, ptr back to 0.
        do_reset();
        req_valid = 4'b0001;
        addr_q[0] = 4'd3;
        @(negedge clk);
        check("rst_grant_ready", req_ready, 4'b0001);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready_suppressed", req_ready, 0);
        check("rst_rsp_valid_during", rsp_valid, 0);
        next_cycle();
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("rst_rsp_valid_after", rsp_valid, 0);
        next_cycle();
        req_valid = 4'b1111;
        @(negedge clk);
        check("rst_ptr_zero", req_ready, 4'b0001);
        next_cycle();
        req_valid = '0;
        next_cycle();

`ifdef ROM_ARB_LOCK_EN
        // Requester 1 holds a lock for three beats while 0 and 2 wait.
        do_reset();
        req_valid = 4'b0001;
        @(negedge clk);
        check("lock_setup_ready", req_ready, 4'b0001);
        next_cycle();
        req_valid = 4'b0111;
        order = '{1, 1, 1, 2, 0, 0};
        for (int c = 0; c < 5; c++) begin
            req_lock = (c < 2) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            check("lock_ready", req_ready, 32'd1 << order[c]);
            next_cycle();
        end
        req_valid = '0;
        req_lock = '0;
        next_cycle();
`endif

        // Randomized traffic against the model.
        do_reset();
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) mode = int'($urandom_range(0, 3));
            case (mode)
                0:       req_valid = N'($urandom);
                1:       req_valid = '1;
                2:       req_valid = N'(1) << $urandom_range(0, N - 1);
                default: req_valid = N'($urandom & $urandom);
            endcase
            for (int i = 0; i < N; i++) addr_q[i] = AW'($urandom);
`ifdef ROM_ARB_LOCK_EN
            req_lock = N'($urandom & $urandom);
`endif
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            next_cycle();
        end
        rst = 1'b0;
        req_valid = '0;
        next_cycle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
- Shares one synchronous-read ROM (`rom` block, 1-cycle read latency) between NUM_REQ requesters using round-robin arbitration.
- Accepts at most one request per cycle, drives the ROM address, and returns the read data one cycle later, tagged with the winner's ID.
- Sits between the ROM instance and the client blocks (table lookups, microcode fetch).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, ROM data width; must match the ROM instance.
- DEPTH, 16, ROM depth; must match the ROM instance.
- ADDR_W, $clog2(DEPTH), ROM address width.
- ID_W, $clog2(NUM_REQ), requester ID width (minimum 1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i = requester i has a pending read.
- req_addr  in  NUM_REQ*ADDR_W  address of requester i in slice [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot grant; combinational this cycle.
- rom_addr  out  ADDR_W  to ROM addr_rd.
- rom_data  in  WIDTH  from ROM data_out.
- rsp_valid  out  1  read data for the previous grant is present.
- rsp_id  out  ID_W  requester that owns rsp_data.
- rsp_data  out  WIDTH  equals rom_data, passed through.

Behaviour:
- Handshake: a transfer happens on a cycle where req_valid[i] && req_ready[i]. req_ready is asserted only to a valid requester. At most one bit of req_ready is set.
- Clients hold req_valid and req_addr stable until granted. The arbiter does not rely on a client keeping req_valid high while it waits.
- Arbitration: priority pointer ptr (ID_W bits). Search starts at ptr and wraps modulo NUM_REQ. The first valid requester wins.
- Pointer update: on a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Throughput and latency: one grant per cycle, no bubbles.
  - Grant in cycle T drives rom_addr = req_addr[winner] in cycle T.
  - The ROM registers data at the T/T+1 edge.
  - In cycle T+1: rsp_valid=1, rsp_id=winner, rsp_data=rom_data.
- Idle: with no grant, rom_addr holds its last driven value (registered copy, no toggling) and rsp_valid=0 the next cycle.
- No response backpressure: clients must accept rsp in the cycle it is presented. Each client qualifies the response with rsp_id.
- Internal state: ptr, last_addr (ADDR_W), rsp_valid_q, rsp_id_q.
- Reset values: ptr=0, last_addr=0 (so rom_addr=0 when idle), rsp_valid=0, rsp_id=0, req_ready=0 while rst=1.
- Reset mid-operation: a grant in the cycle rst is high is suppressed. A read in flight when rst asserts is dropped, so rsp_valid=0 in the cycle after rst.
- All requesters valid every cycle: grants rotate 0,1,2,3,0,... with no starvation. Worst-case wait is NUM_REQ-1 cycles.
- Single requester valid every cycle: granted every cycle regardless of ptr.

Optional Feature:
- Macro: ROM_ARB_LOCK_EN.
- Defined: adds port req_lock (in, NUM_REQ).
  - If requester i is granted with req_lock[i]=1, it keeps the grant on following cycles while req_valid[i]=1, regardless of ptr. This supports back-to-back table walks.
  - ptr does not advance while the lock is held.
  - Lock releases on a granted beat with req_lock[i]=0 (ptr then advances to i+1), or when req_valid[i] drops.
  - Lock state resets to unlocked.
- Undefined: the port is absent and every grant advances ptr.

Decomposition:
- Package rom_arb_pkg:
  - function clog2_min1 for ID_W.
  - localparam RSP_LATENCY = 1, the ROM read latency checked by the bench.
- Sub-module rr_pick: combinational rotate / priority-find / rotate-back. Inputs valid vector and ptr; outputs one-hot grant and grant index.

Test Plan:
- Reset then idle, no req_valid → req_ready=0, rsp_valid=0, rom_addr=0 for 10 cycles.
- Req 2 alone, addr 5, ROM[5]=8'hA5 → req_ready=4'b0100 in T; rsp_valid=1, rsp_id=2, rsp_data=8'hA5 in T+1.
- All 4 valid continuously, addrs 0..3 → grant order 0,1,2,3,0,1 on consecutive cycles; responses match ROM[id] one cycle later; no idle cycles.
- Req 1 and req 3 valid, ptr=2 → req 3 granted first, then req 1, then req 3.
- rst asserted the cycle after a grant to req 0 → rsp_valid=0 in the next cycle; ptr=0 afterward.
- ROM_ARB_LOCK_EN: req 1 locked for 3 beats while req 0 and req 2 are valid → grants 1,1,1, then 2, then 0.
